// File: rtl/classifier_pkg.sv
// Shared types and helpers for the classifier frequency-domain stage.
// Holds the scanner state encoding and the bin-spacing rule.
package classifier_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } scan_state_t;

   // Bin spacing: fs * 2^DECIMAL_PT / N, with N a power of two.
   function automatic logic [63:0] bin_step(
      input logic [63:0] sampling_freq,
      input int unsigned log2_n = 4,
      input int unsigned dec_pt = 16
   );
      if (log2_n > dec_pt)
         return sampling_freq >> (log2_n - dec_pt);
      return sampling_freq << (dec_pt - log2_n);
   endfunction

endpackage

// File: rtl/band_accumulator.sv
// Band energy register: inclusive range test and saturating add.
// o_energy_nxt exposes the value the register takes on the next edge.
module band_accumulator #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_clr,
   input  logic         i_en,
   input  logic [W-1:0] i_freq,
   input  logic [W-1:0] i_lo,
   input  logic [W-1:0] i_hi,
   input  logic [W-1:0] i_mag,
   output logic [W-1:0] o_energy,
   output logic [W-1:0] o_energy_nxt
);

   logic [W-1:0] r_energy;
   logic         w_in_band;
   logic [W:0]   w_sum;
   logic [W-1:0] w_sat;

   always_comb begin
      w_in_band = (i_freq >= i_lo) && (i_freq <= i_hi);
      w_sum     = {1'b0, r_energy} + {1'b0, i_mag};
      w_sat     = w_sum[W] ? '1 : w_sum[W-1:0];
      o_energy_nxt = (i_en && w_in_band) ? w_sat : r_energy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_energy <= '0;
      else if (i_clr)
         r_energy <= '0;
      else
         r_energy <= o_energy_nxt;
   end

   assign o_energy = r_energy;

endmodule

// File: rtl/classifier_band_scanner.sv
// Frame sequencer: walks N FFT bins, accumulates in-band energy
// and hands one classification result per frame downstream.
module classifier_band_scanner
   import classifier_pkg::*;
#(
   parameter int unsigned BIT_WIDTH  = 32,
   parameter int unsigned DECIMAL_PT = 16,
   parameter int unsigned N_SAMPLES  = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] sampling_freq,
   input  logic [BIT_WIDTH-1:0] cutoff_freq_lo,
   input  logic [BIT_WIDTH-1:0] cutoff_freq_hi,
   input  logic [BIT_WIDTH-1:0] cutoff_mag,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_WIDTH-1:0] in_mag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_classify,
   output logic [BIT_WIDTH-1:0] out_energy,
   output logic                 busy
);

   localparam int unsigned LG = $clog2(N_SAMPLES);
   localparam logic [LG-1:0] LAST = LG'(N_SAMPLES - 1);

   scan_state_t          r_state;
   logic [LG-1:0]        r_idx;
   logic [BIT_WIDTH-1:0] r_freq;
   logic [BIT_WIDTH-1:0] r_step;
   logic [BIT_WIDTH-1:0] r_lo;
   logic [BIT_WIDTH-1:0] r_hi;
   logic [BIT_WIDTH-1:0] r_cut;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic                 r_busy;
   logic                 r_classify;

   logic                 w_hs;
   logic                 w_clr;
   logic [BIT_WIDTH-1:0] w_energy_nxt;

   assign w_hs  = in_valid & r_in_ready;
   assign w_clr = (r_state == IDLE) & start;

   band_accumulator #(.W(BIT_WIDTH)) u_acc (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_clr        (w_clr),
      .i_en         (w_hs),
      .i_freq       (r_freq),
      .i_lo         (r_lo),
      .i_hi         (r_hi),
      .i_mag        (in_mag),
      .o_energy     (out_energy),
      .o_energy_nxt (w_energy_nxt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_freq      <= '0;
         r_step      <= '0;
         r_lo        <= '0;
         r_hi        <= '0;
         r_cut       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_classify  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_step     <= BIT_WIDTH'(bin_step(64'(sampling_freq),
                                                    LG, DECIMAL_PT));
                  r_lo       <= cutoff_freq_lo;
                  r_hi       <= cutoff_freq_hi;
                  r_cut      <= cutoff_mag;
                  r_freq     <= '0;
                  r_idx      <= '0;
                  r_classify <= 1'b0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               if (w_hs) begin
                  r_freq <= r_freq + r_step;
                  r_idx  <= r_idx + LG'(1);
                  // Classify from the post-add energy so it lands with out_valid.
                  if (r_idx == LAST) begin
                     r_classify  <= (w_energy_nxt > r_cut);
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign out_classify = r_classify;
   assign busy         = r_busy;

endmodule

// File: tb/tb_classifier_band_scanner.sv
// Directed bench for classifier_band_scanner with an expected-result queue.
// Frames are modelled in the bench and checked at each result handshake.
module tb_classifier_band_scanner;

   localparam int W  = 32;
   localparam int N  = 16;
   localparam int TO = 200;

   logic         clk;
   logic         reset_n;
   logic         start;
   logic [W-1:0] sampling_freq;
   logic [W-1:0] cutoff_freq_lo;
   logic [W-1:0] cutoff_freq_hi;
   logic [W-1:0] cutoff_mag;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_mag;
   logic         out_valid;
   logic         out_ready;
   logic         out_classify;
   logic [W-1:0] out_energy;
   logic         busy;

   int checks = 0;
   int passed = 0;

   logic [W-1:0] sb_e[$];
   logic         sb_c[$];

   classifier_band_scanner #(
      .BIT_WIDTH  (W),
      .DECIMAL_PT (16),
      .N_SAMPLES  (N)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .sampling_freq  (sampling_freq),
      .cutoff_freq_lo (cutoff_freq_lo),
      .cutoff_freq_hi (cutoff_freq_hi),
      .cutoff_mag     (cutoff_mag),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_mag         (in_mag),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_classify   (out_classify),
      .out_energy     (out_energy),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: bin i sits at i * (16 << 12) for fs = 16, N = 16.
   task automatic model(input logic [W-1:0] lo, input logic [W-1:0] hi,
                        input logic [W-1:0] cut, input logic [W-1:0] mag,
                        output logic [W-1:0] e, output logic c);
      logic [W-1:0] f;
      logic [W:0]   s;
      e = '0;
      for (int i = 0; i < N; i++) begin
         f = W'(i * 32'h0001_0000);
         if (f >= lo && f <= hi) begin
            s = {1'b0, e} + {1'b0, mag};
            e = s[W] ? '1 : s[W-1:0];
         end
      end
      c = (e > cut);
   endtask

   task automatic run_frame(input string nm, input logic [W-1:0] lo,
                            input logic [W-1:0] hi, input logic [W-1:0] cut,
                            input logic [W-1:0] mag, input bit gaps,
                            input int bp, input bit chk_lat);
      logic [W-1:0] e;
      logic         c;
      int           cyc;
      model(lo, hi, cut, mag, e, c);
      sb_e.push_back(e);
      sb_c.push_back(c);
      sampling_freq  = 32'd16;
      cutoff_freq_lo = lo;
      cutoff_freq_hi = hi;
      cutoff_mag     = cut;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_busy_start"}, busy, 1);
      chk({nm, "_rdy_start"}, in_ready, 1);
      cyc = 0;
      while (!out_valid && cyc < TO) begin
         in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
         in_mag   = mag;
         start    = gaps && (cyc == 3);
         tick();
         start = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      if (cyc >= TO) chk({nm, "_timeout"}, 0, 1);
      if (chk_lat) chk({nm, "_latency"}, cyc, N);
      chk({nm, "_rdy_done"}, in_ready, 0);
      for (int k = 0; k < bp; k++) begin
         out_ready = 1'b0;
         start     = gaps;
         tick();
         start = 1'b0;
         chk({nm, "_bp_valid"}, out_valid, 1);
         chk({nm, "_bp_energy"}, out_energy, sb_e[0]);
      end
      out_ready = 1'b1;
      start     = gaps;
      chk({nm, "_valid"}, out_valid, 1);
      chk({nm, "_energy"}, out_energy, sb_e.pop_front());
      chk({nm, "_classify"}, out_classify, sb_c.pop_front());
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      chk({nm, "_valid_clr"}, out_valid, 0);
      chk({nm, "_busy_clr"}, busy, 0);
      chk({nm, "_idle_rdy"}, in_ready, 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      start          = 1'b0;
      sampling_freq  = '0;
      cutoff_freq_lo = '0;
      cutoff_freq_hi = '0;
      cutoff_mag     = '0;
      in_valid       = 1'b0;
      in_mag         = '0;
      out_ready      = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_classify", out_classify, 0);
      chk("rst_busy", busy, 0);
      chk("rst_energy", out_energy, 0);
      reset_n = 1'b1;
      tick();

      run_frame("nominal", 32'h3_0000, 32'h5_0000, 32'h2_0000,
                32'h1_0000, 1'b0, 0, 1'b1);
      run_frame("tie", 32'h3_0000, 32'h5_0000, 32'h3_0000,
                32'h1_0000, 1'b0, 0, 1'b0);
      run_frame("sat", 32'h0, 32'hF_0000, 32'hFFFF_FFFE,
                32'hFFFF_0000, 1'b0, 0, 1'b0);
      run_frame("gaps_bp", 32'h3_0000, 32'h5_0000, 32'h2_0000,
                32'h1_0000, 1'b1, 5, 1'b0);
      run_frame("edge_hi", 32'hF_0000, 32'hF_0000, 32'h4,
                32'h5, 1'b0, 1, 1'b0);

      sampling_freq  = 32'd16;
      cutoff_freq_lo = 32'h3_0000;
      cutoff_freq_hi = 32'h5_0000;
      cutoff_mag     = 32'h2_0000;
      start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_mag   = 32'h1_0000;
      repeat (7) tick();
      in_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_energy", out_energy, 0);
      chk("mrst_classify", out_classify, 0);
      tick();
      reset_n = 1'b1;
      tick();

      run_frame("post_rst", 32'h3_0000, 32'h5_0000, 32'h2_0000,
                32'h1_0000, 1'b0, 0, 1'b1);
      run_frame("empty", 32'h9_0000, 32'h2_0000, 32'h0,
                32'h1_0000, 1'b0, 2, 1'b0);

      chk("sb_drained", sb_e.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
